pht_update_scheduler: RTL and testbench
=======================================

// Module: pht_update_scheduler
// PURPOSE
//   Owns the single write port of the pattern history table (PHT) 2-bit counter RAM.
//   Out of reset, and on clear_i, it sweeps every entry to weakly-not-taken (2'b01).
//   It then accepts branch-resolution updates from two commit slots and buffers them in a FIFO.
//   It issues at most one PHT write per cycle, with last-write forwarding to correct stale counters.
// PARAMETERS
//   ADDR_WIDTH   8   PHT index width; table depth = 2**ADDR_WIDTH
//   FIFO_DEPTH   4   update FIFO entries; power of two, >= 2
// PORTS
//   clk            in   1           clock; all state on rising edge
//   rst            in   1           asynchronous reset, active-high
//   clear_i        in   1           pulse: flush FIFO, restart init sweep
//   upd0_valid_i   in   1           slot0 update valid (older than slot1 in same cycle)
//   upd0_ready_o   out  1           slot0 accept
//   upd0_index_i   in   ADDR_WIDTH  slot0 PHT index
//   upd0_taken_i   in   1           slot0 resolved direction
//   upd0_phr_i     in   2           slot0 counter value read at predict time
//   upd1_valid_i / upd1_ready_o / upd1_index_i / upd1_taken_i / upd1_phr_i   same, slot1
//   pht_we_o       out  1           PHT write enable
//   pht_windex_o   out  ADDR_WIDTH  PHT write index
//   pht_taken_o    out  1           PHT taken input
//   pht_phr_o      out  2           PHT old-counter input (PHT computes saturating next value)
//   init_busy_o    out  1           1 = sweep in progress; predictor treats reads as not-taken
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-high (rst).
//   - FSM states: S_INIT, S_RUN.
//     - rst or clear_i -> S_INIT, sweep_idx=0, FIFO count=0, last_vld=0.
//     - S_INIT -> S_RUN on the edge that writes sweep_idx == 2**ADDR_WIDTH-1.
//     - clear_i has priority over every other event, in either state (also restarts a sweep in progress).
//   - Reset values: state=S_INIT, sweep_idx=0, count=0, last_vld=0.
//     - While rst is high: pht_we_o=0, ready outputs=0, init_busy_o=1.
//   - S_INIT outputs (combinational from registers only):
//     - pht_we_o=1, pht_windex_o=sweep_idx, pht_taken_o=1, pht_phr_o=2'b00 (PHT writes 2'b01).
//     - init_busy_o=1, both ready outputs=0.
//     - sweep_idx increments by 1 per cycle; the full sweep takes 2**ADDR_WIDTH cycles.
//   - Ready rules (registered occupancy only; no dependency on valid, no same-cycle dequeue credit):
//     - upd0_ready_o = S_RUN & (count <= FIFO_DEPTH-1).
//     - upd1_ready_o = S_RUN & (count <= FIFO_DEPTH-2).
//   - Enqueue on valid&ready. If both slots fire, slot0 goes to tail and slot1 to tail+1.
//     If only slot1 fires, it goes to tail.
//   - Dequeue in S_RUN when count!=0:
//     - pht_we_o=1, with windex/taken taken from the FIFO head.
//     - Head popped on the same edge.
//   - Latency: an update accepted at edge N drives pht_we_o during the cycle after edge N,
//     if the FIFO was empty before edge N.
//   - Forwarding: last_idx/last_ctr hold the index and the new counter value of the most recent
//     S_RUN write; last_vld=1 after any S_RUN write.
//     - If last_vld & head.index==last_idx: pht_phr_o=last_ctr, else head.phr.
//     - last_ctr = saturating counter: 11/10/01/00 step +1 on taken, -1 on not-taken,
//       clamped to 00..11 (the same function the PHT applies).
//   - Pointer arithmetic: head/tail are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//     - count is log2(FIFO_DEPTH)+1 bits.
//     - count_next = count + enq_count - deq.
//   - Simultaneous enqueue to a full-minus-one FIFO with a dequeue is legal; the ready rules prevent overflow.
//   - Updates presented during S_INIT are not accepted (ready=0); requesters hold them.
//   - clear_i in the same cycle as a handshake: the handshake is ignored (ready forced 0 that cycle)
//     and the FIFO is flushed.
// TESTING
//   - Reset release, ADDR_WIDTH=4:
//     - 16 consecutive writes, idx 0..15, taken=1, phr=00, init_busy_o=1.
//     - Cycle 17: init_busy_o=0, pht_we_o=0.
//   - Single slot0 update {idx=5, taken=1, phr=01}:
//     - Next cycle pht_we_o=1, windex=5, phr=01, taken=1; count returns to 0.
//   - Both slots, same index 9, phr=01 each, taken=1:
//     - Writes in order slot0 then slot1.
//     - Second write has pht_phr_o=2'b10 (forwarded, not 01).
//   - Hold both slots valid continuously, FIFO_DEPTH=4:
//     - upd1_ready_o drops when count>=3 and upd0_ready_o drops when count==4.
//     - No entry lost or duplicated; write order matches acceptance order.
//   - clear_i with 3 entries queued:
//     - Queued entries are never written.
//     - Sweep restarts at idx 0 next cycle, init_busy_o=1, last_vld=0.
//   - rst asserted mid-sweep at idx 7:
//     - Outputs go low immediately.
//     - After release, the sweep restarts at idx 0.

Source files
------------

// File: rtl/pht_update_if.sv
// -----------------------------------------------------------------------------
// pht_update_if
//   Bundle of the update-scheduler signals: the flush request, the two
//   commit-slot update handshakes, the PHT write port and the init-busy flag.
//   master : commit / predictor side (drives updates and clear, sees writes)
//   slave  : pht_update_scheduler
// -----------------------------------------------------------------------------
interface pht_update_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  clear_i;

   logic                  upd0_valid_i;
   logic                  upd0_ready_o;
   logic [ADDR_WIDTH-1:0] upd0_index_i;
   logic                  upd0_taken_i;
   logic [1:0]            upd0_phr_i;

   logic                  upd1_valid_i;
   logic                  upd1_ready_o;
   logic [ADDR_WIDTH-1:0] upd1_index_i;
   logic                  upd1_taken_i;
   logic [1:0]            upd1_phr_i;

   logic                  pht_we_o;
   logic [ADDR_WIDTH-1:0] pht_windex_o;
   logic                  pht_taken_o;
   logic [1:0]            pht_phr_o;
   logic                  init_busy_o;

   modport master (
      output clear_i,
      output upd0_valid_i, upd0_index_i, upd0_taken_i, upd0_phr_i,
      output upd1_valid_i, upd1_index_i, upd1_taken_i, upd1_phr_i,
      input  upd0_ready_o, upd1_ready_o,
      input  pht_we_o, pht_windex_o, pht_taken_o, pht_phr_o, init_busy_o
   );

   modport slave (
      input  clear_i,
      input  upd0_valid_i, upd0_index_i, upd0_taken_i, upd0_phr_i,
      input  upd1_valid_i, upd1_index_i, upd1_taken_i, upd1_phr_i,
      output upd0_ready_o, upd1_ready_o,
      output pht_we_o, pht_windex_o, pht_taken_o, pht_phr_o, init_busy_o
   );
endinterface

// File: rtl/pht_update_scheduler.sv
// -----------------------------------------------------------------------------
// pht_update_scheduler
//   Owns the single write port of the PHT 2-bit counter RAM. After reset or a
//   clear it sweeps every entry to weakly-not-taken (PHT computes 01 from
//   old=00, taken=1). In run mode it buffers branch-resolution updates from
//   two commit slots in a small FIFO and retires one write per cycle, patching
//   the old-counter value when the head hits the index written last cycle(s).
//
// Ports
//   clk   : clock, all state on rising edge
//   rst   : asynchronous reset, active-high
//   bus   : pht_update_if.slave
//           clear_i                 flush FIFO, restart sweep (highest priority)
//           updN_valid/ready/index/taken/phr   commit slot N (slot0 is older)
//           pht_we/windex/taken/phr PHT write port
//           init_busy_o             sweep in progress
// -----------------------------------------------------------------------------
module pht_update_scheduler #(
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   pht_update_if.slave bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]         SLOT0_MAX  = CW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0]         SLOT1_MAX  = CW'(FIFO_DEPTH - 2);
   localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] index;
      logic                  taken;
      logic [1:0]            phr;
   } entry_t;

   // Same saturating step the PHT applies to the counter it is given.
   function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      else
         return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
   endfunction

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] sweep_idx_reg, sweep_idx_next;
   logic [PW-1:0]         head_reg, head_next;
   logic [PW-1:0]         tail_reg, tail_next;
   logic [CW-1:0]         count_reg, count_next;
   logic                  last_vld_reg, last_vld_next;
   logic [ADDR_WIDTH-1:0] last_idx_reg, last_idx_next;
   logic [1:0]            last_ctr_reg, last_ctr_next;

   entry_t                fifo_mem [FIFO_DEPTH];

   entry_t                head_entry, slot0_entry, slot1_entry;
   logic [PW-1:0]         slot1_ptr;
   logic                  enq0, enq1, deq;
   logic [1:0]            fwd_phr;

   logic                  ready0, ready1;
   logic                  we;
   logic [ADDR_WIDTH-1:0] windex;
   logic                  wtaken;
   logic [1:0]            wphr;
   logic                  busy;

   assign slot0_entry = '{index: bus.upd0_index_i, taken: bus.upd0_taken_i, phr: bus.upd0_phr_i};
   assign slot1_entry = '{index: bus.upd1_index_i, taken: bus.upd1_taken_i, phr: bus.upd1_phr_i};
   assign head_entry  = fifo_mem[head_reg];
   // slot1 lands behind slot0 when both fire, otherwise it takes the tail.
   assign slot1_ptr   = tail_reg + PW'(enq0);

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      sweep_idx_next = sweep_idx_reg;
      head_next      = head_reg;
      tail_next      = tail_reg;
      count_next     = count_reg;
      last_vld_next  = last_vld_reg;
      last_idx_next  = last_idx_reg;
      last_ctr_next  = last_ctr_reg;

      ready0  = 1'b0;
      ready1  = 1'b0;
      enq0    = 1'b0;
      enq1    = 1'b0;
      deq     = 1'b0;
      fwd_phr = head_entry.phr;
      we      = 1'b0;
      windex  = head_entry.index;
      wtaken  = head_entry.taken;
      wphr    = fwd_phr;
      busy    = 1'b1;

      case (state_reg)
         S_INIT: begin
            // Sweep outputs depend on registers only.
            we             = 1'b1;
            windex         = sweep_idx_reg;
            wtaken         = 1'b1;
            wphr           = 2'b00;
            busy           = 1'b1;
            sweep_idx_next = sweep_idx_reg + ADDR_WIDTH'(1);
            if (sweep_idx_reg == SWEEP_LAST)
               state_next = S_RUN;
         end

         S_RUN: begin
            busy = 1'b0;
            // A clear cycle neither accepts nor retires anything.
            if (!bus.clear_i) begin
               ready0 = (count_reg <= SLOT0_MAX);
               ready1 = (count_reg <= SLOT1_MAX);
               enq0   = ready0 & bus.upd0_valid_i;
               enq1   = ready1 & bus.upd1_valid_i;
               deq    = (count_reg != '0);

               // The phr captured at predict time is stale if this index was
               // just written; use the counter we know the PHT now holds.
               if (last_vld_reg && (head_entry.index == last_idx_reg))
                  fwd_phr = last_ctr_reg;

               we     = deq;
               windex = head_entry.index;
               wtaken = head_entry.taken;
               wphr   = fwd_phr;

               if (deq) begin
                  head_next     = head_reg + PW'(1);
                  last_vld_next = 1'b1;
                  last_idx_next = head_entry.index;
                  last_ctr_next = sat_next(fwd_phr, head_entry.taken);
               end

               tail_next  = tail_reg + PW'(enq0) + PW'(enq1);
               count_next = count_reg + CW'(enq0) + CW'(enq1) - CW'(deq);
            end
         end

         default: ;
      endcase

      if (bus.clear_i) begin
         state_next     = S_INIT;
         sweep_idx_next = '0;
         head_next      = '0;
         tail_next      = '0;
         count_next     = '0;
         last_vld_next  = 1'b0;
      end

      // Keep the PHT and requesters quiet for as long as reset is held.
      if (rst) begin
         we     = 1'b0;
         ready0 = 1'b0;
         ready1 = 1'b0;
         busy   = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_INIT;
         sweep_idx_reg <= '0;
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         last_vld_reg  <= 1'b0;
         last_idx_reg  <= '0;
         last_ctr_reg  <= 2'b00;
      end else begin
         state_reg     <= state_next;
         sweep_idx_reg <= sweep_idx_next;
         head_reg      <= head_next;
         tail_reg      <= tail_next;
         count_reg     <= count_next;
         last_vld_reg  <= last_vld_next;
         last_idx_reg  <= last_idx_next;
         last_ctr_reg  <= last_ctr_next;
      end
   end

   // FIFO storage: contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (enq0)
         fifo_mem[tail_reg] <= slot0_entry;
      if (enq1)
         fifo_mem[slot1_ptr] <= slot1_entry;
   end

   assign bus.upd0_ready_o = ready0;
   assign bus.upd1_ready_o = ready1;
   assign bus.pht_we_o     = we;
   assign bus.pht_windex_o = windex;
   assign bus.pht_taken_o  = wtaken;
   assign bus.pht_phr_o    = wphr;
   assign bus.init_busy_o  = busy;

endmodule

// File: tb/tb_pht_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pht_update_scheduler
//   Bench for pht_update_scheduler with ADDR_WIDTH=4, FIFO_DEPTH=4.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge. A negedge monitor keeps a queue of accepted updates and
//   compares every run-mode PHT write against it.
// -----------------------------------------------------------------------------
module tb_pht_update_scheduler;

   localparam int AW = 4;
   localparam int FD = 4;

   typedef struct {
      logic [AW-1:0] idx;
      logic          taken;
      logic [1:0]    phr;
   } upd_t;

   typedef struct {
      logic [AW-1:0] idx;
      logic          taken;
      logic [1:0]    phr;
      logic [1:0]    exp_phr;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pht_update_if #(.ADDR_WIDTH(AW)) bus ();

   pht_update_scheduler #(
      .ADDR_WIDTH(AW),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int   n_checks = 0;
   int   n_fail   = 0;

   upd_t sbq[$];
   logic sb_en    = 1'b0;
   logic fired0   = 1'b0;
   logic fired1   = 1'b0;
   int   acc_cnt  = 0;
   int   wr_cnt   = 0;
   int   max_q    = 0;

   logic          m_last_vld = 1'b0;
   logic [AW-1:0] m_last_idx = '0;
   logic [1:0]    m_last_ctr = 2'b00;

   vec_t vecs[11];

   function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
      logic [1:0] r;
      r = c;
      if (t && c != 2'b11) r = c + 2'b01;
      if (!t && c != 2'b00) r = c - 2'b01;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin : monitor
      upd_t       e;
      logic [1:0] ephr;
      if (sb_en && !rst) begin
         if (bus.clear_i) begin
            chk("clear_cycle_quiet",
                32'({bus.pht_we_o, bus.upd0_ready_o, bus.upd1_ready_o}), 32'(3'b000));
            sbq.delete();
            m_last_vld = 1'b0;
            fired0     = 1'b0;
            fired1     = 1'b0;
         end else begin
            chk("ready_vs_count",
                32'({bus.init_busy_o, bus.upd0_ready_o, bus.upd1_ready_o}),
                32'({1'b0, (sbq.size() < FD), (sbq.size() <= FD - 2)}));
            if (sbq.size() > max_q) max_q = sbq.size();
            chk("write_when_nonempty", 32'(bus.pht_we_o), 32'(sbq.size() != 0));
            if (bus.pht_we_o && sbq.size() != 0) begin
               e    = sbq.pop_front();
               ephr = (m_last_vld && m_last_idx == e.idx) ? m_last_ctr : e.phr;
               $display("write idx=%0d taken=%0b phr=%b (expected idx=%0d taken=%0b phr=%b)",
                        bus.pht_windex_o, bus.pht_taken_o, bus.pht_phr_o, e.idx, e.taken, ephr);
               chk("write_order",
                   32'({bus.pht_windex_o, bus.pht_taken_o, bus.pht_phr_o}),
                   32'({e.idx, e.taken, ephr}));
               wr_cnt++;
               m_last_vld = 1'b1;
               m_last_idx = e.idx;
               m_last_ctr = sat2(ephr, e.taken);
            end
            fired0 = bus.upd0_valid_i && bus.upd0_ready_o;
            fired1 = bus.upd1_valid_i && bus.upd1_ready_o;
            if (fired0) begin
               sbq.push_back('{idx: bus.upd0_index_i, taken: bus.upd0_taken_i, phr: bus.upd0_phr_i});
               acc_cnt++;
            end
            if (fired1) begin
               sbq.push_back('{idx: bus.upd1_index_i, taken: bus.upd1_taken_i, phr: bus.upd1_phr_i});
               acc_cnt++;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic set0(input int s);
      bus.upd0_index_i = 4'(s);
      bus.upd0_taken_i = ~s[1];
      bus.upd0_phr_i   = 2'(s >> 2);
   endtask

   task automatic set1(input int s);
      bus.upd1_index_i = 4'(s);
      bus.upd1_taken_i = ~s[1];
      bus.upd1_phr_i   = 2'(s >> 2);
   endtask

   task automatic check_sweep(input string name);
      for (int i = 0; i < (1 << AW); i++) begin
         @(negedge clk);
         chk(name,
             32'({bus.pht_we_o, bus.pht_windex_o, bus.pht_taken_o, bus.pht_phr_o,
                  bus.init_busy_o, bus.upd0_ready_o, bus.upd1_ready_o}),
             32'({1'b1, 4'(i), 1'b1, 2'b00, 1'b1, 1'b0, 1'b0}));
      end
      @(negedge clk);
      chk("sweep_done",
          32'({bus.init_busy_o, bus.pht_we_o, bus.upd0_ready_o, bus.upd1_ready_o}),
          32'(4'b0011));
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int seq;
      int k;

      // idx, taken, phr, expected pht_phr_o (forwarded where the index repeats)
      vecs[0]  = '{4'd5,  1'b1, 2'b01, 2'b01};
      vecs[1]  = '{4'd5,  1'b1, 2'b01, 2'b10};
      vecs[2]  = '{4'd5,  1'b1, 2'b00, 2'b11};
      vecs[3]  = '{4'd5,  1'b0, 2'b11, 2'b11};
      vecs[4]  = '{4'd3,  1'b0, 2'b00, 2'b00};
      vecs[5]  = '{4'd3,  1'b0, 2'b10, 2'b00};
      vecs[6]  = '{4'd3,  1'b1, 2'b11, 2'b00};
      vecs[7]  = '{4'd12, 1'b1, 2'b10, 2'b10};
      vecs[8]  = '{4'd15, 1'b0, 2'b01, 2'b01};
      vecs[9]  = '{4'd0,  1'b1, 2'b11, 2'b11};
      vecs[10] = '{4'd15, 1'b1, 2'b11, 2'b11};

      rst              = 1'b1;
      bus.clear_i      = 1'b0;
      bus.upd0_valid_i = 1'b0;
      bus.upd1_valid_i = 1'b0;
      set0(0);
      set1(0);

      // Reset state
      #12;
      chk("reset_outputs",
          32'({bus.pht_we_o, bus.upd0_ready_o, bus.upd1_ready_o, bus.init_busy_o}),
          32'(4'b0001));
      @(posedge clk); #1;
      rst = 1'b0;
      check_sweep("init_sweep");
      sb_en = 1'b1;

      // Single slot0 updates, one at a time
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         bus.upd0_valid_i = 1'b1;
         bus.upd0_index_i = vecs[i].idx;
         bus.upd0_taken_i = vecs[i].taken;
         bus.upd0_phr_i   = vecs[i].phr;
         @(posedge clk); #1;
         bus.upd0_valid_i = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_write", i),
             32'({bus.pht_we_o, bus.pht_windex_o, bus.pht_taken_o, bus.pht_phr_o}),
             32'({1'b1, vecs[i].idx, vecs[i].taken, vecs[i].exp_phr}));
         @(negedge clk);
         chk($sformatf("vec%0d_idle", i), 32'(bus.pht_we_o), 32'(1'b0));
      end

      // Both slots, same index: second write sees the first one's result
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b1; bus.upd0_index_i = 4'd9; bus.upd0_taken_i = 1'b1; bus.upd0_phr_i = 2'b01;
      bus.upd1_valid_i = 1'b1; bus.upd1_index_i = 4'd9; bus.upd1_taken_i = 1'b1; bus.upd1_phr_i = 2'b01;
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b0;
      bus.upd1_valid_i = 1'b0;
      @(negedge clk);
      chk("same_idx_first",
          32'({bus.pht_we_o, bus.pht_windex_o, bus.pht_phr_o}), 32'({1'b1, 4'd9, 2'b01}));
      @(negedge clk);
      chk("same_idx_second",
          32'({bus.pht_we_o, bus.pht_windex_o, bus.pht_phr_o}), 32'({1'b1, 4'd9, 2'b10}));
      @(negedge clk);
      chk("same_idx_idle", 32'(bus.pht_we_o), 32'(1'b0));

      // Both slots held valid continuously
      seq = 16;
      set0(seq); seq++;
      set1(seq); seq++;
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b1;
      bus.upd1_valid_i = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         if (fired0) begin set0(seq); seq++; end
         if (fired1) begin set1(seq); seq++; end
      end
      bus.upd0_valid_i = 1'b0;
      bus.upd1_valid_i = 1'b0;
      k = 0;
      while (k < 40 && sbq.size() != 0) begin
         @(negedge clk);
         k++;
      end
      chk("stress_drained", 32'(sbq.size()), 32'(0));
      chk("stress_wr_vs_acc", 32'(wr_cnt), 32'(acc_cnt));
      chk("stress_fifo_peak", 32'(max_q), 32'(3));

      // clear_i with three entries queued
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b1; bus.upd0_index_i = 4'd7; bus.upd0_taken_i = 1'b1; bus.upd0_phr_i = 2'b10;
      bus.upd1_valid_i = 1'b1; bus.upd1_index_i = 4'd2; bus.upd1_taken_i = 1'b0; bus.upd1_phr_i = 2'b01;
      @(posedge clk); #1;
      bus.upd0_index_i = 4'd4; bus.upd0_taken_i = 1'b1; bus.upd0_phr_i = 2'b00;
      bus.upd1_index_i = 4'd6; bus.upd1_taken_i = 1'b0; bus.upd1_phr_i = 2'b11;
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b0;
      bus.upd1_valid_i = 1'b0;
      bus.clear_i      = 1'b1;
      @(negedge clk);
      chk("clear_busy_still_run", 32'(bus.init_busy_o), 32'(1'b0));
      @(posedge clk); #1;
      bus.clear_i = 1'b0;
      sb_en       = 1'b0;
      check_sweep("clear_sweep");
      sb_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("flushed_not_written", 32'(bus.pht_we_o), 32'(1'b0));
      end
      // Index 7 was the last run-mode write before the clear; no forwarding now.
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b1; bus.upd0_index_i = 4'd7; bus.upd0_taken_i = 1'b1; bus.upd0_phr_i = 2'b00;
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b0;
      @(negedge clk);
      chk("post_clear_no_fwd",
          32'({bus.pht_we_o, bus.pht_windex_o, bus.pht_phr_o}), 32'({1'b1, 4'd7, 2'b00}));

      // rst in the middle of a sweep
      @(posedge clk); #1;
      bus.clear_i = 1'b1;
      @(posedge clk); #1;
      bus.clear_i = 1'b0;
      sb_en       = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_sweep_idx7",
          32'({bus.pht_we_o, bus.pht_windex_o, bus.init_busy_o}), 32'({1'b1, 4'd7, 1'b1}));
      #1;
      rst = 1'b1;
      #1;
      chk("rst_outputs_immediate",
          32'({bus.pht_we_o, bus.upd0_ready_o, bus.upd1_ready_o, bus.init_busy_o}),
          32'(4'b0001));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst        = 1'b0;
      m_last_vld = 1'b0;
      sbq.delete();
      check_sweep("rst_sweep");
      sb_en = 1'b1;

      // One more pair after the restart
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b1; bus.upd0_index_i = 4'd3; bus.upd0_taken_i = 1'b0; bus.upd0_phr_i = 2'b11;
      bus.upd1_valid_i = 1'b1; bus.upd1_index_i = 4'd3; bus.upd1_taken_i = 1'b0; bus.upd1_phr_i = 2'b11;
      @(posedge clk); #1;
      bus.upd0_valid_i = 1'b0;
      bus.upd1_valid_i = 1'b0;
      @(negedge clk);
      chk("post_rst_first",
          32'({bus.pht_we_o, bus.pht_windex_o, bus.pht_phr_o}), 32'({1'b1, 4'd3, 2'b11}));
      @(negedge clk);
      chk("post_rst_second",
          32'({bus.pht_we_o, bus.pht_windex_o, bus.pht_phr_o}), 32'({1'b1, 4'd3, 2'b10}));
      @(negedge clk);
      chk("final_drained", 32'(sbq.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
